mem_access_stage: RTL and testbench

//  - Memory (M) stage of the 5-stage pipeline. It consumes M_input from the X->M forwarding logic (read, write, addr, forwarded store value, dst).
//  - It sequences data-memory requests over a valid/ready request channel and a valid-only response channel.
//  - It produces the writeback record for the W stage and stalls upstream while a memory access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 33 +++
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 132 +++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline types for the memory-access stage: data records, op and state encodings.
package mem_access_stage_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_REG_W  = 5;

    typedef logic                  Signal;
    typedef logic [MEM_DATA_W-1:0] Register;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        Register               val;
        logic [MEM_REG_W-1:0]  dst;
    } M_data;

    typedef struct packed {
        Signal read;
        Signal write;
        M_data data;
    } M_input;

    typedef struct packed {
        Register              val;
        logic [MEM_REG_W-1:0] dst;
        Signal                wr_en;
    } W_data;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_e;

    typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE} mem_op_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: valid/ready request channel plus valid-only response channel.
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_rsp_valid;
    logic [DATA_W-1:0] dmem_rsp_data;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );
endinterface

// File: rtl/mem_access_stage.sv
// M stage: sequences one data-memory access at a time and emits the W-stage record.
// Optional MEM_MISALIGN_CHECK_EN: misaligned loads/stores are squashed and flag sticky misalign_err.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned REG_W  = MEM_REG_W
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   m_valid,
    input  M_input m_in,
    output logic   m_ready,
    output logic   stall,
    mem_access_stage_if.master dmem,
    output logic   w_valid,
    output W_data  w_out,
    output logic   misalign_err
);

    mem_state_e        state, state_nxt;
    mem_op_e           op_q, op_in;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] val_q;
    logic [REG_W-1:0]  dst_q;
    logic              capture;
    logic              misalign_hit;
    logic              w_valid_nxt;
    W_data             w_out_nxt;

    // read wins over write when both strobes are set
    always_comb begin
        op_in = OP_ALU;
        if (m_in.read)
            op_in = OP_LOAD;
        else if (m_in.write)
            op_in = OP_STORE;
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_hit = (op_in != OP_ALU) && (m_in.data.addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_err <= 1'b0;
        else if (state == IDLE && m_valid && misalign_hit)
            misalign_err <= 1'b1;
    end
`else
    assign misalign_hit = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        w_valid_nxt = 1'b0;
        w_out_nxt   = '0;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    if (op_in == OP_ALU) begin
                        w_valid_nxt     = 1'b1;
                        w_out_nxt.val   = m_in.data.addr;
                        w_out_nxt.dst   = m_in.data.dst;
                        w_out_nxt.wr_en = (m_in.data.dst != '0);
                    end else if (misalign_hit) begin
                        w_valid_nxt   = 1'b1;
                        w_out_nxt.dst = m_in.data.dst;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_req_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt     = IDLE;
                        w_valid_nxt   = 1'b1;
                        w_out_nxt.dst = dst_q;
                    end
                end
            end
            WAIT: begin
                if (dmem.dmem_rsp_valid) begin
                    state_nxt       = IDLE;
                    w_valid_nxt     = 1'b1;
                    w_out_nxt.val   = dmem.dmem_rsp_data;
                    w_out_nxt.dst   = dst_q;
                    w_out_nxt.wr_en = (dst_q != '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_ALU;
            addr_q  <= '0;
            val_q   <= '0;
            dst_q   <= '0;
            w_valid <= 1'b0;
            w_out   <= '0;
        end else begin
            state   <= state_nxt;
            w_valid <= w_valid_nxt;
            w_out   <= w_out_nxt;
            if (capture) begin
                op_q   <= op_in;
                addr_q <= m_in.data.addr;
                val_q  <= m_in.data.val;
                dst_q  <= m_in.data.dst;
            end
        end
    end

    assign m_ready = (state == IDLE);
    assign stall   = ~m_ready;

    // bus fields are zero outside REQ so reset and idle look identical downstream
    assign dmem.dmem_req_valid = (state == REQ);
    assign dmem.dmem_we        = (state == REQ) && (op_q == OP_STORE);
    assign dmem.dmem_addr      = (state == REQ) ? addr_q : '0;
    assign dmem.dmem_wdata     = (state == REQ) ? val_q  : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus W-record scoreboard.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] val;
        logic [4:0]  dst;
        int unsigned req_dly;
        int unsigned rsp_dly;
        logic [31:0] rsp_data;
        logic [31:0] e_val;
        logic        e_wr_en;
        logic        chk_dst;
    } vec_t;

    typedef struct {
        logic [31:0] val;
        logic [4:0]  dst;
        logic        wr_en;
        logic        chk_dst;
    } exp_t;

    logic   clk     = 1'b0;
    logic   reset   = 1'b1;
    logic   m_valid = 1'b0;
    M_input m_in    = '0;
    logic   m_ready, stall, w_valid, misalign_err;
    W_data  w_out;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    mem_access_stage_if dmem_bus ();

    mem_access_stage dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_in         (m_in),
        .m_ready      (m_ready),
        .stall        (stall),
        .dmem         (dmem_bus),
        .w_valid      (w_valid),
        .w_out        (w_out),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && w_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_w_valid: got w_valid=1 expected no pending record");
            end else begin
                e = sb.pop_front();
                chk("w_val", w_out.val, e.val);
                chk("w_wr_en", 32'(w_out.wr_en), 32'(e.wr_en));
                if (e.chk_dst)
                    chk("w_dst", 32'(w_out.dst), 32'(e.dst));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        chk({tag, "_m_ready"}, 32'(m_ready), 32'd1);
        m_valid          = 1'b1;
        m_in.read        = v.rd;
        m_in.write       = v.wr;
        m_in.data.addr   = v.addr;
        m_in.data.val    = v.val;
        m_in.data.dst    = v.dst;
        e.val     = v.e_val;
        e.dst     = v.dst;
        e.wr_en   = v.e_wr_en;
        e.chk_dst = v.chk_dst;
        sb.push_back(e);
        @(posedge clk); #1;
        m_valid = 1'b0;
        m_in    = '0;
        if (!(v.rd || v.wr)) begin
            @(negedge clk);
            chk({tag, "_alu_w_valid"}, 32'(w_valid), 32'd1);
            chk({tag, "_alu_no_req"}, 32'(dmem_bus.dmem_req_valid), 32'd0);
        end else begin
            for (int unsigned i = 0; i <= v.req_dly; i++) begin
                @(negedge clk);
                chk({tag, "_req_valid"}, 32'(dmem_bus.dmem_req_valid), 32'd1);
                chk({tag, "_req_stall"}, 32'(stall), 32'd1);
                chk({tag, "_req_we"}, 32'(dmem_bus.dmem_we), 32'(!v.rd));
                chk({tag, "_req_addr"}, dmem_bus.dmem_addr, v.addr);
                if (!v.rd)
                    chk({tag, "_req_wdata"}, dmem_bus.dmem_wdata, v.val);
                if (i == v.req_dly)
                    dmem_bus.dmem_req_ready = 1'b1;
                @(posedge clk); #1;
                dmem_bus.dmem_req_ready = 1'b0;
            end
            if (v.rd) begin
                for (int unsigned j = 0; j <= v.rsp_dly; j++) begin
                    @(negedge clk);
                    chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
                    chk({tag, "_wait_no_req"}, 32'(dmem_bus.dmem_req_valid), 32'd0);
                    chk({tag, "_wait_no_w"}, 32'(w_valid), 32'd0);
                    if (j == v.rsp_dly) begin
                        dmem_bus.dmem_rsp_valid = 1'b1;
                        dmem_bus.dmem_rsp_data  = v.rsp_data;
                    end
                    @(posedge clk); #1;
                    dmem_bus.dmem_rsp_valid = 1'b0;
                    dmem_bus.dmem_rsp_data  = '0;
                end
            end
            @(negedge clk);
            chk({tag, "_done_w_valid"}, 32'(w_valid), 32'd1);
            chk({tag, "_done_m_ready"}, 32'(m_ready), 32'd1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_w_out_val"}, w_out.val, 32'd0);
        chk({tag, "_w_out_rest"}, 32'({w_out.dst, w_out.wr_en}), 32'd0);
        chk({tag, "_req_valid"}, 32'(dmem_bus.dmem_req_valid), 32'd0);
        chk({tag, "_we"}, 32'(dmem_bus.dmem_we), 32'd0);
        chk({tag, "_addr"}, dmem_bus.dmem_addr, 32'd0);
        chk({tag, "_wdata"}, dmem_bus.dmem_wdata, 32'd0);
        chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
        chk({tag, "_m_ready"}, 32'(m_ready), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t alu_v;
        //           rd    wr    addr          val           dst    rq rs rsp_data      e_val         e_wr  chk_dst
        tbl[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,        5'd5,  0, 0, 32'h0,        32'h0000_1234, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        5'd0,  0, 0, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 5'd2,  2, 0, 32'h0,        32'h0,         1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        5'd7,  0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,        5'd0,  0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0088, 32'h0000_0055, 5'd3,  1, 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 5'd9,  0, 0, 32'h0,        32'h0,         1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        5'd31, 1, 0, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b1, 1'b1};
        alu_v  = '{1'b0, 1'b0, 32'h0000_ABCD, 32'h0,        5'd12, 0, 0, 32'h0,        32'h0000_ABCD, 1'b1, 1'b1};

        dmem_bus.dmem_req_ready = 1'b0;
        dmem_bus.dmem_rsp_valid = 1'b0;
        dmem_bus.dmem_rsp_data  = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i], $sformatf("v%0d", i));

        // a stray response while idle must not produce a record
        @(negedge clk);
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_data  = 32'hFFFF_0000;
        @(posedge clk); #1;
        dmem_bus.dmem_rsp_valid = 1'b0;
        dmem_bus.dmem_rsp_data  = '0;
        @(negedge clk);
        chk("idle_rsp_no_w", 32'(w_valid), 32'd0);
        chk("idle_rsp_m_ready", 32'(m_ready), 32'd1);

        // reset while a load waits for its response, then a late response
        @(negedge clk);
        m_valid        = 1'b1;
        m_in.read      = 1'b1;
        m_in.data.addr = 32'h0000_0200;
        m_in.data.dst  = 5'd6;
        @(posedge clk); #1;
        m_valid = 1'b0;
        m_in    = '0;
        @(negedge clk);
        chk("rst_wait_req_valid", 32'(dmem_bus.dmem_req_valid), 32'd1);
        dmem_bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_bus.dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_wait_stall", 32'(stall), 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("rst_wait");
        @(negedge clk);
        reset = 1'b0;
        dmem_bus.dmem_rsp_valid = 1'b1;
        dmem_bus.dmem_rsp_data  = 32'h0000_0077;
        @(posedge clk); #1;
        dmem_bus.dmem_rsp_valid = 1'b0;
        dmem_bus.dmem_rsp_data  = '0;
        @(negedge clk);
        chk("late_rsp_no_w", 32'(w_valid), 32'd0);
        chk("late_rsp_m_ready", 32'(m_ready), 32'd1);
        run_vec(alu_v, "post_rst_alu");

`ifdef MEM_MISALIGN_CHECK_EN
        begin
            exp_t e;
            @(negedge clk);
            chk("mis_pre", 32'(misalign_err), 32'd0);
            m_valid        = 1'b1;
            m_in.read      = 1'b1;
            m_in.data.addr = 32'h0000_0042;
            m_in.data.dst  = 5'd4;
            e.val = 32'h0; e.dst = 5'd4; e.wr_en = 1'b0; e.chk_dst = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            m_valid = 1'b0;
            m_in    = '0;
            @(negedge clk);
            chk("mis_w_valid", 32'(w_valid), 32'd1);
            chk("mis_no_req", 32'(dmem_bus.dmem_req_valid), 32'd0);
            chk("mis_err_set", 32'(misalign_err), 32'd1);
            chk("mis_m_ready", 32'(m_ready), 32'd1);
            run_vec(alu_v, "mis_alu");
            @(negedge clk);
            chk("mis_err_sticky", 32'(misalign_err), 32'd1);
            #1 reset = 1'b1;
            #1 chk("mis_err_reset", 32'(misalign_err), 32'd0);
            @(negedge clk);
            reset = 1'b0;
        end
`else
        begin
            vec_t mis_v;
            mis_v = '{1'b1, 1'b0, 32'h0000_0042, 32'h0, 5'd4, 0, 0, 32'h0BEE_F000, 32'h0BEE_F000, 1'b1, 1'b1};
            run_vec(mis_v, "unaligned_load");
            chk("no_misalign_flag", 32'(misalign_err), 32'd0);
        end
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
